// File: rtl/layer_output_collector.sv
// -----------------------------------------------------------------------------
// layer_output_collector
//
// Gathers one sample from each of NUM_NEURON neurons (captured on the rising
// edge of that neuron's level valid), then replays the buffer in index order
// as a valid/ready stream for the next layer.
//
// Optional feature (macro LAYER_ARGMAX_EN): tracks the signed arg-max over
// the streamed layer. Without the macro the arg-max outputs are tied to 0.
//
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_neuron_data     packed neuron outputs, neuron k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_neuron_valid    per-neuron level valid
//   o_data, o_index   stream element and its neuron index
//   o_valid, i_ready  stream handshake
//   o_layer_done      one-cycle pulse after the last element transfers
//   o_overrun         sticky: sample overwritten in COLLECT or dropped in DRAIN
//   o_max_index       arg-max index of the last completed layer
//   o_max_valid       pulses together with o_layer_done (arg-max builds only)
// -----------------------------------------------------------------------------
module layer_output_collector #(
   parameter int NUM_NEURON = 30,
   parameter int DATA_WIDTH = 16,
   parameter int IDX_WIDTH  = $clog2(NUM_NEURON)
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_neuron_data,
   input  logic [NUM_NEURON-1:0]            i_neuron_valid,
   output logic [DATA_WIDTH-1:0]            o_data,
   output logic [IDX_WIDTH-1:0]             o_index,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic                             o_layer_done,
   output logic                             o_overrun,
   output logic [IDX_WIDTH-1:0]             o_max_index,
   output logic                             o_max_valid
);

   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   buffer [NUM_NEURON];
   logic [NUM_NEURON-1:0]   r_prev;
   logic [NUM_NEURON-1:0]   captured;
   logic [NUM_NEURON-1:0]   events;
   logic [NUM_NEURON-1:0]   captured_next;
   logic [IDX_WIDTH-1:0]    index;
   logic                    xfer;
   logic                    last;

   assign events        = i_neuron_valid & ~r_prev;
   assign captured_next = captured | events;
   assign xfer          = o_valid & i_ready;
   assign last          = (index == IDX_WIDTH'(NUM_NEURON - 1));
   assign o_data        = buffer[index];
   assign o_index       = index;

   // Sample storage has no reset; contents are meaningless until captured.
   always_ff @(posedge i_clk) begin
      if (state == COLLECT) begin
         for (int unsigned k = 0; k < NUM_NEURON; k++) begin
            if (events[k]) buffer[k] <= i_neuron_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= COLLECT;
         r_prev       <= '0;
         captured     <= '0;
         index        <= '0;
         o_valid      <= 1'b0;
         o_layer_done <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         // Edge detector keeps tracking in every state so a valid held high
         // across a drain cannot re-trigger afterwards.
         r_prev       <= i_neuron_valid;
         o_layer_done <= 1'b0;
         case (state)
            COLLECT: begin
               captured <= captured_next;
               if (|(events & captured)) o_overrun <= 1'b1;
               if (&captured_next) begin
                  state   <= DRAIN;
                  o_valid <= 1'b1;
                  index   <= '0;
               end
            end
            DRAIN: begin
               if (|events) o_overrun <= 1'b1;
               if (xfer) begin
                  if (last) begin
                     state        <= COLLECT;
                     o_valid      <= 1'b0;
                     captured     <= '0;
                     index        <= '0;
                     o_layer_done <= 1'b1;
                  end else begin
                     index <= index + IDX_WIDTH'(1);
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

`ifdef LAYER_ARGMAX_EN
   logic signed [DATA_WIDTH-1:0] max_val;
   logic [IDX_WIDTH-1:0]         max_idx;
   logic                         take;

   // Index 0 seeds the running max; strictly-greater keeps the lowest index on ties.
   assign take = (index == '0) || ($signed(o_data) > max_val);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         max_val     <= '0;
         max_idx     <= '0;
         o_max_index <= '0;
         o_max_valid <= 1'b0;
      end else begin
         o_max_valid <= 1'b0;
         if (xfer) begin
            if (take) begin
               max_val <= $signed(o_data);
               max_idx <= index;
            end
            // Final element folds into the result directly so it lands with o_layer_done.
            if (last) begin
               o_max_valid <= 1'b1;
               o_max_index <= take ? index : max_idx;
            end
         end
      end
   end
`else
   assign o_max_index = '0;
   assign o_max_valid = 1'b0;
`endif

endmodule
